dio_test_controller: RTL

DIO_TEST_CONTROLLER -- requirements
Module: dio_test_controller

---
 rtl/dio_test_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dio_test_controller.sv
// dio_test_controller: sends a DIO checker config, scores status beats over a dwell window, then sends the off word.
// Define DIO_CTRL_FIRST_FAIL_EN to capture the index of the first failing CHECK beat.
module dio_test_controller #(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_clock_div,
  input  logic [7:0]  cfg_phase,
  input  logic [1:0]  cfg_mode,
  input  logic [15:0] cfg_dwell,
  output logic [31:0] dio_settings_tdata,
  output logic        dio_settings_tvalid,
  input  logic        dio_settings_tready,
  input  logic [31:0] dio_counter_status_tdata,
  input  logic        dio_counter_status_tvalid,
  output logic        dio_counter_status_tready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        cfg_fault,
  output logic [15:0] error_bits,
  output logic [15:0] fail_count,
  output logic [15:0] first_fail_beat
);
  localparam logic [2:0] IDLE = 3'd0, SEND_CFG = 3'd1, SETTLE = 3'd2, CHECK = 3'd3,
                         SEND_OFF = 3'd4, WAIT_OFF = 3'd5, DONE = 3'd6;
  localparam logic [15:0] LAST_SETTLE = 16'(SETTLE_CYCLES - 1);
  logic [2:0]  state;
  logic [7:0]  div, phase;
  logic [15:0] dwell, cnt, last_dwell;
  logic        aborted, chk_beat, fail_beat, set_hs, unused;
  assign last_dwell = dwell == 16'd0 ? 16'd0 : dwell - 16'd1;
  assign dio_counter_status_tready = state == SETTLE || state == CHECK;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign set_hs = dio_settings_tvalid && dio_settings_tready;
  assign chk_beat = state == CHECK && dio_counter_status_tvalid;
  assign fail_beat = chk_beat && |dio_counter_status_tdata[15:0];
  assign unused = ^dio_counter_status_tdata[31:18];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      dio_settings_tdata <= '0;
      dio_settings_tvalid <= 1'b0;
      pass <= 1'b0;
      cfg_fault <= 1'b0;
      error_bits <= '0;
      fail_count <= '0;
      div <= '0;
      phase <= '0;
      dwell <= '0;
      cnt <= '0;
      aborted <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div <= cfg_clock_div;
          phase <= cfg_phase;
          dwell <= cfg_dwell;
          dio_settings_tdata <= {14'b0, cfg_mode, cfg_phase, cfg_clock_div};
          dio_settings_tvalid <= 1'b1;
          pass <= 1'b0;
          cfg_fault <= 1'b0;
          error_bits <= '0;
          fail_count <= '0;
          aborted <= 1'b0;
          cnt <= '0;
          state <= SEND_CFG;
        end
        SEND_CFG: begin
          if (abort) aborted <= 1'b1;
          // an abort here must not tear the pending transfer; it only redirects after the handshake
          if (set_hs && (abort || aborted)) begin
            dio_settings_tdata <= {16'b0, phase, div};
            state <= SEND_OFF;
          end else if (set_hs) begin
            dio_settings_tvalid <= 1'b0;
            cnt <= '0;
            state <= SETTLE;
          end
        end
        SETTLE, CHECK: begin
          if (abort) aborted <= 1'b1;
          if (abort || (state == CHECK && cnt == last_dwell)) begin
            dio_settings_tvalid <= 1'b1;
            dio_settings_tdata <= {16'b0, phase, div};
            state <= SEND_OFF;
          end else if (state == SETTLE && cnt == LAST_SETTLE) begin
            cnt <= '0;
            state <= CHECK;
          end else cnt <= cnt + 16'd1;
        end
        SEND_OFF: if (set_hs) begin
          dio_settings_tvalid <= 1'b0;
          state <= WAIT_OFF;
        end
        WAIT_OFF: begin
          pass <= error_bits == 16'd0 && !cfg_fault && !aborted;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (chk_beat) begin
        error_bits <= error_bits | dio_counter_status_tdata[15:0];
        if (dio_counter_status_tdata[17:16] != 2'b00) cfg_fault <= 1'b1;
      end
      if (fail_beat && fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
    end
  end
`ifdef DIO_CTRL_FIRST_FAIL_EN
  logic [15:0] beat_idx;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_idx <= '0;
      first_fail_beat <= '0;
    end else if (state == IDLE && start) begin
      beat_idx <= '0;
      first_fail_beat <= 16'hFFFF;
    end else if (chk_beat) begin
      beat_idx <= beat_idx + 16'd1;
      if (fail_beat && first_fail_beat == 16'hFFFF) first_fail_beat <= beat_idx;
    end
  end
`else
  assign first_fail_beat = '0;
`endif
endmodule
